// File: rtl/cs_pkg.sv
// Shared types and width helpers for the carrier-sense energy detector.
package cs_pkg;

   typedef enum logic [1:0] {IDLE, ACCUM, DECIDE} state_e;

   function automatic int pwr_w(input int width);
      return 2 * width + 1;
   endfunction

   function automatic int acc_w(input int width, input int win_log2);
      return pwr_w(width) + win_log2;
   endfunction

endpackage

// File: rtl/cs_energy_detector_if.sv
// Sample/threshold/result bundle between a sample source and cs_energy_detector.
interface cs_energy_detector_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 32
);
   import cs_pkg::*;
   localparam int PWR_W = pwr_w(WIDTH);

   logic                    run;
   logic                    strobe;
   logic signed [WIDTH-1:0] real_value;
   logic signed [WIDTH-1:0] img_value;
   logic [PWR_W-1:0]        threshold_hi;
   logic [PWR_W-1:0]        threshold_lo;
   logic                    present_next;
   logic [CNT_W-1:0]        present_nextcount;
   logic [PWR_W-1:0]        energy;
   logic                    energy_valid;

   modport master (
      output run, strobe, real_value, img_value, threshold_hi, threshold_lo,
      input  present_next, present_nextcount, energy, energy_valid
   );

   modport slave (
      input  run, strobe, real_value, img_value, threshold_hi, threshold_lo,
      output present_next, present_nextcount, energy, energy_valid
   );

endinterface

// File: rtl/cs_mag_sq.sv
// Stage 1: registered instantaneous power I^2 + Q^2 of each accepted sample.
module cs_mag_sq
   import cs_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     strobe,
   input  logic signed [WIDTH-1:0]  i_val,
   input  logic signed [WIDTH-1:0]  q_val,
   output logic [pwr_w(WIDTH)-1:0]  p,
   output logic                     p_vld
);
   localparam int PWR_W = pwr_w(WIDTH);

   logic signed [2*WIDTH-1:0] i_ext, q_ext, i_sq, q_sq;
   logic [PWR_W-1:0]          p_d, p_q;
   logic                      vld_d, vld_q;

   assign i_ext = (2*WIDTH)'(i_val);
   assign q_ext = (2*WIDTH)'(q_val);
   assign i_sq  = i_ext * i_ext;
   assign q_sq  = q_ext * q_ext;

   // Squares are non-negative, so the extra bit only has to absorb the carry.
   always_comb begin
      vld_d = en & strobe;
      p_d   = p_q;
      if (vld_d) p_d = PWR_W'(unsigned'(i_sq)) + PWR_W'(unsigned'(q_sq));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_q   <= '0;
         vld_q <= 1'b0;
      end else begin
         p_q   <= p_d;
         vld_q <= vld_d;
      end
   end

   assign p     = p_q;
   assign p_vld = vld_q;

endmodule

// File: rtl/cs_energy_detector.sv
// Windowed mean-power carrier-sense detector with busy-window counter.
// Define CS_HYST_EN to decide busy/idle with hi/lo hysteresis thresholds.
module cs_energy_detector
   import cs_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int WIN_LOG2 = 8,
   parameter int CNT_W    = 32
) (
   input logic                 clk,
   input logic                 rst,
   cs_energy_detector_if.slave bus
);
   localparam int PWR_W = pwr_w(WIDTH);
   localparam int ACC_W = acc_w(WIDTH, WIN_LOG2);

   state_e              state_d, state_q;
   logic [ACC_W-1:0]    acc_d, acc_q;
   logic [WIN_LOG2-1:0] cnt_d, cnt_q;
   logic [PWR_W-1:0]    energy_d, energy_q;
   logic                ev_d, ev_q;
   logic                pres_d, pres_q;
   logic [CNT_W-1:0]    pcnt_d, pcnt_q;
   logic [PWR_W-1:0]    thr_hi_q;
   logic [PWR_W-1:0]    p;
   logic                p_vld;
   logic [PWR_W-1:0]    energy_new;
   logic                thr_chg;

   cs_mag_sq #(.WIDTH(WIDTH)) u_mag_sq (
      .clk    (clk),
      .rst    (rst),
      .en     (bus.run),
      .strobe (bus.strobe),
      .i_val  (bus.real_value),
      .q_val  (bus.img_value),
      .p      (p),
      .p_vld  (p_vld)
   );

   assign energy_new = acc_q[ACC_W-1:WIN_LOG2];

`ifdef CS_HYST_EN
   logic [PWR_W-1:0] thr_lo_q;
   assign thr_chg = (bus.threshold_hi != thr_hi_q) || (bus.threshold_lo != thr_lo_q);
   always_ff @(posedge clk) begin
      if (rst) thr_lo_q <= '0;
      else     thr_lo_q <= bus.threshold_lo;
   end
`else
   assign thr_chg = (bus.threshold_hi != thr_hi_q);
`endif

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      energy_d = energy_q;
      ev_d     = 1'b0;
      pres_d   = pres_q;
      pcnt_d   = pcnt_q;
      if (!bus.run) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         pres_d  = 1'b0;
      end else if (thr_chg && state_q != IDLE) begin
         // A window straddling a threshold change would be judged against the wrong level.
         state_d = ACCUM;
         acc_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE:  state_d = ACCUM;
            ACCUM: if (p_vld) begin
               acc_d = acc_q + ACC_W'(p);
               cnt_d = cnt_q + WIN_LOG2'(1);
               if (&cnt_q) state_d = DECIDE;
            end
            DECIDE: begin
               energy_d = energy_new;
               ev_d     = 1'b1;
`ifdef CS_HYST_EN
               if (energy_new > bus.threshold_hi)      pres_d = 1'b1;
               else if (energy_new < bus.threshold_lo) pres_d = 1'b0;
`else
               pres_d = (energy_new > bus.threshold_hi);
`endif
               if (pres_d && !(&pcnt_q)) pcnt_d = pcnt_q + CNT_W'(1);
               // Sample landing this cycle opens the next window.
               acc_d   = p_vld ? ACC_W'(p) : '0;
               cnt_d   = p_vld ? WIN_LOG2'(1) : '0;
               state_d = ACCUM;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         energy_q <= '0;
         ev_q     <= 1'b0;
         pres_q   <= 1'b0;
         pcnt_q   <= '0;
         thr_hi_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         energy_q <= energy_d;
         ev_q     <= ev_d;
         pres_q   <= pres_d;
         pcnt_q   <= pcnt_d;
         thr_hi_q <= bus.threshold_hi;
      end
   end

   assign bus.present_next      = pres_q;
   assign bus.present_nextcount = pcnt_q;
   assign bus.energy            = energy_q;
   assign bus.energy_valid      = ev_q;

endmodule

// File: tb/tb_cs_energy_detector.sv
// Bench for cs_energy_detector: window table plus run-drop, threshold-change, reset and saturation sequences.
module tb_cs_energy_detector;

   typedef struct {
      logic [3:0][15:0] i;
      logic [3:0][15:0] q;
      logic [32:0]      thr;
      logic [32:0]      e;
      bit               p;
      int               gap;
   } vec_t;

   typedef struct {
      logic [32:0] e;
      bit          p;
      int          c;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   m_cnt = 0;
   logic [32:0] m_energy = '0;
   exp_t sbq[$];
   vec_t tbl[6];
   vec_t w;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cs_energy_detector_if #(.WIDTH(16), .CNT_W(4)) bus ();

   cs_energy_detector #(.WIDTH(16), .WIN_LOG2(2), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_thr(input logic [32:0] t);
      bus.threshold_hi = t;
      bus.threshold_lo = t + 33'd1;
      step(3);
   endtask

   task automatic strobe_one(input logic [15:0] iv, input logic [15:0] qv);
      bus.strobe     = 1'b1;
      bus.real_value = iv;
      bus.img_value  = qv;
      step(1);
      bus.strobe = 1'b0;
   endtask

   task automatic send_win(input vec_t v);
      exp_t x;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) begin
            if (v.p && m_cnt < 15) m_cnt++;
            m_energy = v.e;
            x.e = v.e; x.p = v.p; x.c = m_cnt; x.cyc = cyc + 3;
            sbq.push_back(x);
         end
         strobe_one(v.i[k], v.q[k]);
         step(v.gap);
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 30 && sbq.size() != 0; n++) step(1);
      if (sbq.size() != 0) begin
         chk("drain_timeout", sbq.size(), 0);
         sbq.delete();
      end
      step(1);
   endtask

   // Scoreboard: every energy_valid pulse must match the oldest pending window.
   always @(negedge clk) begin
      if (bus.energy_valid === 1'b1) begin
         if (sbq.size() == 0) chk("unexpected_ev", 1, 0);
         else begin
            exp_t x;
            x = sbq.pop_front();
            chk("energy", bus.energy, x.e);
            chk("present", bus.present_next, x.p);
            chk("count", bus.present_nextcount, x.c);
            chk("ev_latency", cyc, x.cyc);
         end
      end
   end

   initial begin
      tbl[0] = '{i: {4{16'd100}}, q: '0, thr: 33'd10000, e: 33'd10000, p: 1'b0, gap: 0};
      tbl[1] = '{i: {4{16'd100}}, q: '0, thr: 33'd9999, e: 33'd10000, p: 1'b1, gap: 1};
      tbl[2] = '{i: {4{16'h8000}}, q: {4{16'h8000}}, thr: 33'h0_7FFF_FFFF, e: 33'h0_8000_0000, p: 1'b1, gap: 0};
      tbl[3] = '{i: {4{16'd3}}, q: {4{16'd4}}, thr: 33'd24, e: 33'd25, p: 1'b1, gap: 2};
      tbl[4] = '{i: {4{-16'sd7}}, q: {4{16'd5}}, thr: 33'd74, e: 33'd74, p: 1'b0, gap: 0};
      tbl[5] = '{i: {16'd1, 16'd2, 16'd3, 16'd5}, q: '0, thr: 33'd8, e: 33'd9, p: 1'b1, gap: 0};

      rst = 1'b1;
      bus.run = 1'b0; bus.strobe = 1'b0;
      bus.real_value = '0; bus.img_value = '0;
      bus.threshold_hi = '0; bus.threshold_lo = '0;
      step(3);
      rst = 1'b0;
      step(1);
      chk("rst_energy", bus.energy, 0);
      chk("rst_present", bus.present_next, 0);
      chk("rst_count", bus.present_nextcount, 0);
      chk("rst_ev", bus.energy_valid, 0);

      for (int n = 0; n < 6; n++) begin
         set_thr(tbl[n].thr);
         if (n == 0) begin
            bus.run = 1'b1;
            step(2);
         end
         send_win(tbl[n]);
         drain();
      end

      // Run dropped mid-window: partial samples must vanish, no pulse.
      set_thr(33'd9999);
      strobe_one(16'd200, 16'd0);
      strobe_one(16'd200, 16'd0);
      step(1);
      bus.run = 1'b0;
      step(4);
      chk("drop_present", bus.present_next, 0);
      chk("drop_count_hold", bus.present_nextcount, m_cnt);
      chk("drop_energy_hold", bus.energy, m_energy);
      bus.run = 1'b1;
      step(1);
      w = '{i: {4{16'd100}}, q: '0, thr: 33'd9999, e: 33'd10000, p: 1'b1, gap: 0};
      send_win(w);
      drain();

      // Threshold change mid-window restarts the window.
      strobe_one(16'd200, 16'd0);
      strobe_one(16'd200, 16'd0);
      step(2);
      set_thr(33'd20000);
      w = '{i: {4{16'd100}}, q: '0, thr: 33'd20000, e: 33'd10000, p: 1'b0, gap: 0};
      send_win(w);
      drain();

      // Reset mid-window clears everything, including the busy count.
      strobe_one(16'd200, 16'd0);
      strobe_one(16'd200, 16'd0);
      rst = 1'b1;
      step(2);
      chk("mid_rst_energy", bus.energy, 0);
      chk("mid_rst_count", bus.present_nextcount, 0);
      chk("mid_rst_present", bus.present_next, 0);
      rst = 1'b0;
      m_cnt = 0;
      set_thr(33'd9999);
      w = '{i: {4{16'd100}}, q: '0, thr: 33'd9999, e: 33'd10000, p: 1'b1, gap: 0};
      send_win(w);
      drain();

      // 20 back-to-back busy windows with alternating power; count saturates.
      for (int n = 0; n < 20; n++) begin
         if (n % 2 == 0) w = '{i: {4{16'd100}}, q: '0, thr: 33'd9999, e: 33'd10000, p: 1'b1, gap: 0};
         else            w = '{i: {4{16'd200}}, q: '0, thr: 33'd9999, e: 33'd40000, p: 1'b1, gap: 0};
         send_win(w);
      end
      drain();
      chk("sat_count", bus.present_nextcount, 15);

`ifdef CS_HYST_EN
      bus.run = 1'b0;
      bus.threshold_hi = 33'd10000;
      bus.threshold_lo = 33'd5000;
      step(3);
      bus.run = 1'b1;
      step(1);
      w = '{i: {16'd200, 16'd80, 16'd0, 16'd0}, q: {16'd0, 16'd40, 16'd0, 16'd0}, thr: 33'd10000, e: 33'd12000, p: 1'b1, gap: 0};
      send_win(w);
      w = '{i: {16'd100, 16'd100, 16'd80, 16'd0}, q: {16'd0, 16'd0, 16'd40, 16'd0}, thr: 33'd10000, e: 33'd7000, p: 1'b1, gap: 0};
      send_win(w);
      w = '{i: {16'd80, 16'd80, 16'd0, 16'd0}, q: {16'd40, 16'd40, 16'd0, 16'd0}, thr: 33'd10000, e: 33'd4000, p: 1'b0, gap: 0};
      send_win(w);
      drain();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cs_energy_detector.md
CS_ENERGY_DETECTOR -- requirements
Module: cs_energy_detector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the signed bit width of the I and Q samples.
REQ-002 The block SHALL have parameter WIN_LOG2, default 8, the log2 of the averaging window length (window = 2^WIN_LOG2 samples).
REQ-003 The block SHALL have parameter CNT_W, default 32, the width of the busy-window counter.
REQ-004 The block SHALL have derived widths PWR_W = 2*WIDTH+1 and ACC_W = PWR_W+WIN_LOG2.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clk (in, 1, rising-edge clock) and rst (in, 1, reset).
REQ-006 The block SHALL have the following inputs: run (in, 1, detector enable); strobe (in, 1, sample valid); real_value (in, WIDTH, signed I); img_value (in, WIDTH, signed Q); threshold_hi (in, PWR_W, unsigned assert threshold).
REQ-007 The block SHALL have input threshold_lo (in, PWR_W, unsigned deassert threshold), used only when CS_HYST_EN is defined.
REQ-008 The block SHALL have the following outputs: present_next (out, 1, channel busy); present_nextcount (out, CNT_W, busy windows seen); energy (out, PWR_W, last window mean power); energy_valid (out, 1, one-cycle pulse per completed window).

Function
REQ-009 The block SHALL run an FSM with states IDLE, ACCUM and DECIDE.
REQ-010 In IDLE, the FSM SHALL go to ACCUM when run=1.
REQ-011 In ACCUM, the FSM SHALL go to DECIDE on the cycle the 2^WIN_LOG2-th squared sample is added.
REQ-012 DECIDE SHALL last one cycle and then return to ACCUM if run=1, else to IDLE.
REQ-013 From any state, run=0 SHALL force IDLE on the next cycle, clear the accumulator and sample counter, and set present_next to 0; present_nextcount and energy SHALL hold.
REQ-014 Stage 1 SHALL register p = I*I + Q*Q as unsigned PWR_W bits, one cycle after strobe=1 with run=1; samples with strobe=0 SHALL be ignored.
REQ-015 Stage 2 SHALL add p into an ACC_W-bit accumulator and increment a WIN_LOG2-bit sample counter; the accumulator SHALL never overflow.
REQ-016 In DECIDE, energy SHALL be set to the accumulator right-shifted by WIN_LOG2 (truncating), energy_valid SHALL pulse high for that cycle, and the accumulator and counter SHALL restart from zero.
REQ-017 Latency: energy_valid SHALL assert exactly 3 cycles after the strobe of the last window sample.
REQ-018 A stage-1 sample arriving in the DECIDE cycle SHALL be counted into the next window, never dropped.
REQ-019 Without hysteresis, DECIDE SHALL set present_next = (energy > threshold_hi), strictly greater.
REQ-020 present_nextcount SHALL increment by 1 in each DECIDE cycle whose new present_next is 1, saturating at 2^CNT_W-1.
REQ-021 If threshold_hi (or threshold_lo) changes value mid-window, the window in progress SHALL be discarded and restarted without an energy_valid pulse; the change SHALL be detected with a registered copy of the threshold.
REQ-022 present_next, present_nextcount and energy SHALL change only in DECIDE, on run=0, or on reset.

Reset
REQ-023 While rst=1, the FSM SHALL be in IDLE, all datapath registers SHALL be 0, and present_next=0, present_nextcount=0, energy=0, energy_valid=0.
REQ-024 Reset SHALL take priority over run and strobe, and reset mid-window SHALL discard all partial accumulation.

Configuration
REQ-025 With macro CS_HYST_EN defined, DECIDE SHALL set present_next to 1 if energy > threshold_hi, to 0 if energy < threshold_lo, and otherwise hold it.
REQ-026 Without CS_HYST_EN, threshold_lo SHALL be unused and REQ-019 SHALL apply.

Structure
REQ-027 Package cs_pkg SHALL hold the FSM state enum and the PWR_W/ACC_W width helper functions.
REQ-028 One sub-module, cs_mag_sq, SHALL implement the registered stage-1 I^2+Q^2.

Verification (WIDTH=16, WIN_LOG2=2, CNT_W=4)
REQ-029 Bench SHALL drive 4 strobes with I=100, Q=0 and threshold_hi=9999 -> energy=10000, energy_valid pulses 3 cycles after the 4th strobe, present_next=1, present_nextcount=1.
REQ-030 Bench SHALL repeat REQ-029 with threshold_hi=10000 -> present_next=0 and present_nextcount=0.
REQ-031 Bench SHALL drive I=Q=-32768 for 4 samples -> energy=2^31 with no overflow.
REQ-032 Bench SHALL drive 20 busy windows -> present_nextcount saturates at 15.
REQ-033 Bench SHALL drop run after 2 strobes, then restart -> no energy_valid pulse, and the next window averages only the new samples.
REQ-034 With CS_HYST_EN, hi=10000 and lo=5000, window energies 12000, 7000, 4000 -> present_next = 1, 1, 0.
